// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte stream to instruction-memory word writer (optional checksum: LOADER_CHECKSUM_EN)
module imem_boot_loader #(
   parameter int                DEPTH     = 256,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_DONE,
      S_ERR
`ifdef LOADER_CHECKSUM_EN
      , S_CSUM
`endif
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_FINISH = S_CSUM;
`else
   localparam state_t S_FINISH = S_DONE;
`endif

   state_t              state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [15:0]         word_idx_q, word_idx_d;
   logic [1:0]          byte_idx_q, byte_idx_d;
   logic [23:0]         buf_q, buf_d;
   logic                in_ready_q, in_ready_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                hold_q, hold_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                accept;
   logic [15:0]         len_full;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]          sum_q, sum_d;
   logic [7:0]          sum_total;
`endif

   assign accept = in_valid & in_ready_q;

   // Next-state and next-output computation for the frame parser
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      buf_d      = buf_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      len_full   = {len_q[15:8], in_data};
`ifdef LOADER_CHECKSUM_EN
      sum_d      = sum_q;
      sum_total  = sum_q + in_data;
`endif
      case (state_q)
         S_LEN_HI: begin
            if (accept) begin
               len_d   = {in_data, 8'h00};
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               len_d = len_full;
               if (len_full == 16'd0)
                  state_d = S_FINISH;
               else if ({1'b0, len_full} > DEPTH_L)
                  state_d = S_ERR;
               else
                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
               sum_d = sum_total;
`endif
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: buf_d[23:16] = in_data;
                  2'd1: buf_d[15:8]  = in_data;
                  2'd2: buf_d[7:0]   = in_data;
                  default: begin
                     // Fourth byte completes the big-endian word; write it next cycle
                     wdata_d    = {buf_q, in_data};
                     we_d       = 1'b1;
                     addr_d     = BASE_ADDR + (ADDR_W'(word_idx_q) << 2);
                     word_idx_d = word_idx_q + 16'd1;
                     if (word_idx_q + 16'd1 == len_q)
                        state_d = S_FINISH;
                  end
               endcase
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept)
               state_d = (sum_total == 8'h00) ? S_DONE : S_ERR;
         end
`endif
         S_DONE, S_ERR: begin
            if (restart) begin
               state_d    = S_LEN_HI;
               len_d      = '0;
               word_idx_d = '0;
               byte_idx_d = '0;
               buf_d      = '0;
`ifdef LOADER_CHECKSUM_EN
               sum_d      = '0;
`endif
            end
         end
         default: state_d = S_LEN_HI;
      endcase

      // Status levels follow the state one cycle late so the last strobe precedes done
      in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
      done_d     = (state_q == S_DONE) && !restart;
      error_d    = (state_q == S_ERR) && !restart;
      hold_d     = !done_d;
   end

   // State and registered outputs; reset discards any partial word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_LEN_HI;
         len_q      <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         buf_q      <= '0;
         in_ready_q <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= BASE_ADDR;
         wdata_q    <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         buf_q      <= buf_d;
         in_ready_q <= in_ready_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        restart;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int tests = 0;
   int fails = 0;
   int late_writes = 0;
   logic [31:0] wa[$];
   logic [31:0] wd[$];

   imem_boot_loader #(.DEPTH(256), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .restart(restart), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Log every write strobe and flag any that coincides with done
   always @(negedge clk) begin
      if (imem_we) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_wdata);
         if (done) late_writes++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) @(negedge clk);
   endtask

   task automatic wait_end;
      int n = 0;
      while (!done && !error && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("end_timeout", 32'(n), 32'd0);
   endtask

   task automatic pulse_restart;
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic send_t2(input int gap);
      logic [7:0] f[10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
      for (int i = 0; i < 10; i++) begin
         send_byte(f[i]);
         if (i >= 2) idle(gap);
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'hA3);
`endif
   endtask

   task automatic check_t2(input string tag);
      check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
      if (wa.size() == 2) begin
         check({tag, "_a0"}, wa[0], 32'h0);
         check({tag, "_d0"}, wd[0], 32'h20080005);
         check({tag, "_a1"}, wa[1], 32'h4);
         check({tag, "_d1"}, wd[1], 32'h20090007);
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
      check({tag, "_err"}, 32'(error), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      restart  = 1'b0;

      // T1 reset with in_valid high
      idle(3);
      check("t1_ready", 32'(in_ready), 32'd1);
      check("t1_hold", 32'(cpu_hold), 32'd1);
      check("t1_we", 32'(imem_we), 32'd0);
      check("t1_done", 32'(done), 32'd0);
      check("t1_err", 32'(error), 32'd0);
      check("t1_addr", imem_addr, 32'h0);
      check("t1_wdata", imem_wdata, 32'h0);
      check("t1_nwr", 32'(wa.size()), 32'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      idle(1);

      // T2 two-word image, back-to-back
      send_t2(0);
      wait_end();
      check_t2("t2");
      in_valid = 1'b1;
      in_data  = 8'h55;
      idle(3);
      check("t2_trail_ready", 32'(in_ready), 32'd0);
      check("t2_trail_nwr", 32'(wa.size()), 32'd2);
      check("t2_trail_done", 32'(done), 32'd1);
      in_valid = 1'b0;
      pulse_restart();
      check("t2_rs_ready", 32'(in_ready), 32'd1);
      check("t2_rs_done", 32'(done), 32'd0);
      check("t2_rs_hold", 32'(cpu_hold), 32'd1);

      // T3 oversize length
      wa.delete(); wd.delete();
      send_byte(8'h01);
      send_byte(8'h01);
      wait_end();
      check("t3_err", 32'(error), 32'd1);
      check("t3_hold", 32'(cpu_hold), 32'd1);
      check("t3_ready", 32'(in_ready), 32'd0);
      check("t3_done", 32'(done), 32'd0);
      check("t3_nwr", 32'(wa.size()), 32'd0);
      pulse_restart();
      check("t3_rs_ready", 32'(in_ready), 32'd1);
      check("t3_rs_err", 32'(error), 32'd0);

      // T4 reset mid-frame after 6 bytes, then full resend
      wa.delete(); wd.delete();
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
      idle(1);
      rst_n = 1'b0;
      #1;
      check("t4_rst_ready", 32'(in_ready), 32'd1);
      check("t4_rst_we", 32'(imem_we), 32'd0);
      check("t4_rst_hold", 32'(cpu_hold), 32'd1);
      idle(1);
      rst_n = 1'b1;
      idle(3);
      check("t4_nwr", 32'(wa.size()), 32'd1);
      wa.delete(); wd.delete();
      send_t2(0);
      wait_end();
      check_t2("t4");
      pulse_restart();

      // T6 in_valid toggling during data
      wa.delete(); wd.delete();
      send_t2(1);
      wait_end();
      check_t2("t6");
      pulse_restart();

`ifdef LOADER_CHECKSUM_EN
      // T5 checksum good then bad
      wa.delete(); wd.delete();
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'hF6);
      wait_end();
      check("t5_good_done", 32'(done), 32'd1);
      check("t5_good_err", 32'(error), 32'd0);
      check("t5_good_nwr", 32'(wa.size()), 32'd1);
      if (wa.size() == 1) check("t5_good_d", wd[0], 32'h01020304);
      pulse_restart();
      wa.delete(); wd.delete();
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'hF5);
      wait_end();
      check("t5_bad_err", 32'(error), 32'd1);
      check("t5_bad_hold", 32'(cpu_hold), 32'd1);
      check("t5_bad_nwr", 32'(wa.size()), 32'd1);
      if (wa.size() == 1) begin
         check("t5_bad_a", wa[0], 32'h0);
         check("t5_bad_d", wd[0], 32'h01020304);
      end
      pulse_restart();
`endif

      check("we_before_done", 32'(late_writes), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
